// File: rtl/result_port.sv
// Snoops `sw Rx, ROM` stores into a byte FIFO and drains them over valid/ready.
// It also keeps a saturating byte count, sticky overflow with first-drop PC, and a DONE drain flag.
module result_port #(
    parameter int         DEPTH    = 8,
    parameter logic [2:0] ROM_ADDR = 3'b111
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [1:0] ProgState,
    input  logic [8:0] Instruction,
    input  logic [7:0] DataOut,
    input  logic [9:0] PC,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] byte_count,
    output logic       overflow,
    output logic [9:0] overflow_pc,
    output logic       drained
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE, ST_HALT} prog_state_e;
    prog_state_e state;
    assign state = prog_state_e'(ProgState);

    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [7:0]  count_q, count_d;
    logic        ovf_q, ovf_d;
    logic [9:0]  ovf_pc_q, ovf_pc_d;
    logic        drained_q, drained_d;
    logic [7:0]  out_data_q, out_data_d;
    logic [7:0]  mem_q [DEPTH];

    logic empty, full, store, pop, push, drop;
    logic unused_ra;
    assign unused_ra = ^Instruction[5:3];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign store = (state == ST_RUN) && (Instruction[8:6] == 3'b001)
                   && (Instruction[2:0] == ROM_ADDR);
    assign out_valid = !empty && (state != ST_HALT);
    assign pop   = out_valid && out_ready && (state != ST_IDLE);
    assign push  = store && (!full || pop);
    assign drop  = store && full && !pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        ovf_pc_d   = ovf_pc_q;
        drained_d  = (state == ST_DONE) && empty;
        out_data_d = out_data_q;
        if (state == ST_IDLE) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            ovf_d     = 1'b0;
            ovf_pc_d  = '0;
            drained_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && count_q != 8'hFF) count_d = count_q + 8'd1;
            if (drop) begin
                ovf_d = 1'b1;
                if (!ovf_q) ovf_pc_d = PC;
            end
        end
        // The byte being written this cycle is not in mem_q yet; forward it if it becomes the head.
        if (push && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0]))
            out_data_d = DataOut;
        else
            out_data_d = mem_q[rd_ptr_d[AW-1:0]];
    end

    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= DataOut;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            ovf_pc_q   <= '0;
            drained_q  <= 1'b0;
            out_data_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            ovf_pc_q   <= ovf_pc_d;
            drained_q  <= drained_d;
            out_data_q <= out_data_d;
        end
    end

    assign out_data    = out_data_q;
    assign byte_count  = count_q;
    assign overflow    = ovf_q;
    assign overflow_pc = ovf_pc_q;
    assign drained     = drained_q;
endmodule

// File: tb/tb_result_port.sv
// Directed vector bench for result_port: table of per-cycle inputs and expected outputs,
// plus a hand-written asynchronous-reset sequence.
module tb_result_port;
    localparam logic [1:0] I = 2'b00, R = 2'b01, D = 2'b10, H = 2'b11;
    localparam logic [8:0] SW  = 9'b001_010_111;
    localparam logic [8:0] LW  = 9'b000_000_111;
    localparam logic [8:0] NOP = 9'b000_000_000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] prog_state = I;
    logic [8:0] instr = NOP;
    logic [7:0] data_in = 8'h00;
    logic [9:0] pc = 10'h000;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic [7:0] byte_count;
    logic       overflow;
    logic [9:0] overflow_pc;
    logic       drained;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    result_port #(.DEPTH(8), .ROM_ADDR(3'b111)) dut (
        .CLK(clk), .RST_N(rst_n), .ProgState(prog_state), .Instruction(instr),
        .DataOut(data_in), .PC(pc), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .byte_count(byte_count), .overflow(overflow),
        .overflow_pc(overflow_pc), .drained(drained)
    );

    typedef struct {
        logic [1:0] st;
        logic [8:0] ins;
        logic [7:0] dout;
        logic [9:0] pc;
        logic       rdy;
        logic       e_valid;
        logic       chk_data;
        logic [7:0] e_data;
        logic [7:0] e_count;
        logic       e_ovf;
        logic [9:0] e_ovpc;
        logic       e_drn;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic [1:0] st, logic [8:0] ins, logic [7:0] dout, logic [9:0] p,
                                logic rdy, logic e_valid, logic chk_data, logic [7:0] e_data,
                                logic [7:0] e_count, logic e_ovf, logic [9:0] e_ovpc, logic e_drn);
        vec_t v;
        v.st = st; v.ins = ins; v.dout = dout; v.pc = p; v.rdy = rdy;
        v.e_valid = e_valid; v.chk_data = chk_data; v.e_data = e_data;
        v.e_count = e_count; v.e_ovf = e_ovf; v.e_ovpc = e_ovpc; v.e_drn = e_drn;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic apply(input int idx, input vec_t v);
        @(negedge clk);
        prog_state = v.st; instr = v.ins; data_in = v.dout; pc = v.pc; out_ready = v.rdy;
        @(posedge clk);
        #1;
        $display("vec %0d st=%0d ins=%b din=%h rdy=%0d -> valid=%0d data=%h cnt=%0d ovf=%0d opc=%h drn=%0d",
                 idx, v.st, v.ins, v.dout, v.rdy, out_valid, out_data, byte_count,
                 overflow, overflow_pc, drained);
        check($sformatf("vec%0d out_valid", idx), int'(out_valid), int'(v.e_valid));
        if (v.chk_data) check($sformatf("vec%0d out_data", idx), int'(out_data), int'(v.e_data));
        check($sformatf("vec%0d byte_count", idx), int'(byte_count), int'(v.e_count));
        check($sformatf("vec%0d overflow", idx), int'(overflow), int'(v.e_ovf));
        check($sformatf("vec%0d overflow_pc", idx), int'(overflow_pc), int'(v.e_ovpc));
        check($sformatf("vec%0d drained", idx), int'(drained), int'(v.e_drn));
    endtask

    initial begin
        vec_t v;
        // Single store, one-cycle latency, then popped.
        add(I, NOP, 8'h00, 10'h000, 1'b0, 1'b0, 1'b0, 8'h00, 8'd0, 1'b0, 10'h000, 1'b0);
        add(R, SW,  8'hA5, 10'h001, 1'b1, 1'b1, 1'b1, 8'hA5, 8'd1, 1'b0, 10'h000, 1'b0);
        add(R, NOP, 8'h00, 10'h002, 1'b1, 1'b0, 1'b0, 8'h00, 8'd1, 1'b0, 10'h000, 1'b0);
        // Fill to full with ready low, then two dropped stores.
        add(I, NOP, 8'h00, 10'h000, 1'b0, 1'b0, 1'b0, 8'h00, 8'd0, 1'b0, 10'h000, 1'b0);
        for (int k = 1; k <= 8; k++)
            add(R, SW, 8'(k), 10'(k), 1'b0, 1'b1, 1'b1, 8'h01, 8'(k), 1'b0, 10'h000, 1'b0);
        add(R, SW, 8'h09, 10'h024, 1'b0, 1'b1, 1'b1, 8'h01, 8'd8, 1'b1, 10'h024, 1'b0);
        add(R, SW, 8'h0A, 10'h030, 1'b0, 1'b1, 1'b1, 8'h01, 8'd8, 1'b1, 10'h024, 1'b0);
        for (int j = 1; j <= 8; j++)
            add(R, NOP, 8'h00, 10'h031, 1'b1, (j < 8), (j < 8), 8'(j + 1), 8'd8, 1'b1, 10'h024, 1'b0);
        // Refill, then simultaneous push and pop while full.
        add(I, NOP, 8'h00, 10'h000, 1'b0, 1'b0, 1'b0, 8'h00, 8'd0, 1'b0, 10'h000, 1'b0);
        for (int k = 0; k < 8; k++)
            add(R, SW, 8'(8'h11 + k), 10'h040, 1'b0, 1'b1, 1'b1, 8'h11, 8'(k + 1), 1'b0, 10'h000, 1'b0);
        add(R, SW, 8'h55, 10'h048, 1'b1, 1'b1, 1'b1, 8'h12, 8'd9, 1'b0, 10'h000, 1'b0);
        for (int j = 1; j <= 8; j++)
            add(R, NOP, 8'h00, 10'h049, 1'b1, (j < 8), (j < 8),
                (j <= 6) ? 8'(8'h12 + j) : 8'h55, 8'd9, 1'b0, 10'h000, 1'b0);
        // Store encoding in DONE and a load in RUN do not push.
        add(D, SW, 8'h66, 10'h050, 1'b1, 1'b0, 1'b0, 8'h00, 8'd9, 1'b0, 10'h000, 1'b1);
        add(R, LW, 8'h77, 10'h051, 1'b1, 1'b0, 1'b0, 8'h00, 8'd9, 1'b0, 10'h000, 1'b0);
        // Three bytes queued, HALT freezes, DONE drains and then reports drained.
        for (int k = 0; k < 3; k++)
            add(R, SW, 8'(8'h21 + k), 10'h060, 1'b0, 1'b1, 1'b1, 8'h21, 8'(10 + k), 1'b0, 10'h000, 1'b0);
        add(H, SW,  8'h44, 10'h063, 1'b1, 1'b0, 1'b0, 8'h00, 8'd12, 1'b0, 10'h000, 1'b0);
        add(H, NOP, 8'h00, 10'h064, 1'b1, 1'b0, 1'b0, 8'h00, 8'd12, 1'b0, 10'h000, 1'b0);
        add(D, NOP, 8'h00, 10'h065, 1'b1, 1'b1, 1'b1, 8'h22, 8'd12, 1'b0, 10'h000, 1'b0);
        add(D, NOP, 8'h00, 10'h066, 1'b1, 1'b1, 1'b1, 8'h23, 8'd12, 1'b0, 10'h000, 1'b0);
        add(D, NOP, 8'h00, 10'h067, 1'b1, 1'b0, 1'b0, 8'h00, 8'd12, 1'b0, 10'h000, 1'b0);
        add(D, NOP, 8'h00, 10'h068, 1'b1, 1'b0, 1'b0, 8'h00, 8'd12, 1'b0, 10'h000, 1'b1);

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", int'(out_valid), 0);
        check("reset out_data", int'(out_data), 0);
        check("reset byte_count", int'(byte_count), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

        // Asynchronous reset in the middle of a stream of four queued bytes.
        v = '{st: I, ins: NOP, dout: 8'h00, pc: 10'h000, rdy: 1'b0, e_valid: 1'b0, chk_data: 1'b0,
              e_data: 8'h00, e_count: 8'd0, e_ovf: 1'b0, e_ovpc: 10'h000, e_drn: 1'b0};
        apply(100, v);
        for (int k = 0; k < 4; k++) begin
            v = '{st: R, ins: SW, dout: 8'(8'h31 + k), pc: 10'h070, rdy: 1'b0, e_valid: 1'b1,
                  chk_data: 1'b1, e_data: 8'h31, e_count: 8'(k + 1), e_ovf: 1'b0,
                  e_ovpc: 10'h000, e_drn: 1'b0};
            apply(101 + k, v);
        end
        @(negedge clk);
        instr = NOP;
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset: valid=%0d data=%h cnt=%0d ovf=%0d opc=%h drn=%0d",
                 out_valid, out_data, byte_count, overflow, overflow_pc, drained);
        check("async rst out_valid", int'(out_valid), 0);
        check("async rst out_data", int'(out_data), 0);
        check("async rst byte_count", int'(byte_count), 0);
        check("async rst overflow", int'(overflow), 0);
        check("async rst overflow_pc", int'(overflow_pc), 0);
        check("async rst drained", int'(drained), 0);
        @(negedge clk);
        rst_n = 1'b1;
        v = '{st: R, ins: SW, dout: 8'h7E, pc: 10'h080, rdy: 1'b0, e_valid: 1'b1, chk_data: 1'b1,
              e_data: 8'h7E, e_count: 8'd1, e_ovf: 1'b0, e_ovpc: 10'h000, e_drn: 1'b0};
        apply(105, v);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/result_port.md
# result_port

Output-side companion to the divisor-capture/exception logic. That logic snoops `lw Rx, RIM` loads from the input memory. This block snoops `sw Rx, ROM` stores from the core to the result output memory, queues each stored byte in a small FIFO, and drains the bytes to the host/testbench over a valid/ready handshake. It also keeps a saturating byte count, a sticky overflow flag with the PC of the first dropped store, and a completion indicator for the `DONE` program state.

## Interface
Parameters:
- `DEPTH`, 8: FIFO depth in bytes; a power of two, ≥2.
- `ROM_ADDR`, 3'b111: register-field code that selects the result output memory.

Ports:
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RST_N` in 1: reset, asynchronous and active-low.
- `ProgState` in 2: 00 = IDLE, 01 = RUN, 10 = DONE, 11 = HALT.
- `Instruction` in 9: current instruction; {opcode[8:6], rA[5:3], rB[2:0]}.
- `DataOut` in 8: value of register rA presented by the core during a store.
- `PC` in 10: address of the current instruction.
- `out_data` out 8: FIFO head byte.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: host accepts the head byte.
- `byte_count` out 8: number of pushes accepted since the last clear; saturates at 255.
- `overflow` out 1: sticky; a store was dropped because the FIFO was full.
- `overflow_pc` out 10: `PC` of the first dropped store.
- `drained` out 1: registered; high when `ProgState` is DONE and the FIFO is empty.

## Operation
- Store detect: `store = (ProgState==01) && Instruction[8:6]==3'b001 && Instruction[2:0]==ROM_ADDR`. rA is any register.
- Push:
  - A push on `store` captures `DataOut` at the tail.
  - A push is accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
- Pop: `pop = out_valid && out_ready`. Pops are legal in every `ProgState` except IDLE.
- Dropped store (full and no pop):
  - `DataOut` is discarded and the FIFO contents are unchanged.
  - `overflow` is set.
  - `overflow_pc` is loaded with `PC` only if `overflow` was previously 0.
- Push and pop on an empty FIFO do not bypass: the pushed byte appears on `out_data` in the following cycle.
- FIFO implementation: read/write pointers of log2(DEPTH)+1 bits. Full means the MSBs differ and the low bits are equal; empty means the pointers are equal. Pointers wrap modulo 2·DEPTH.
- `byte_count` increments on each accepted push and holds at 255.
- IDLE (00) is a synchronous clear of pointers, `byte_count`, `overflow`, `overflow_pc` and `drained`. `out_valid` drops the next cycle.
- RUN (01): captures stores and drains.
- DONE (10): no capture; drains; `drained` is asserted once the FIFO is empty.
- HALT (11): no capture, no pop, all state frozen; `out_valid` is forced to 0.
- A change of `ProgState` takes effect in the same cycle for store detect and the pop gate.

## Timing
- Reset values (asynchronous on `RST_N`=0): `out_data` 0, `out_valid` 0, `byte_count` 0, `overflow` 0, `overflow_pc` 0, `drained` 0, pointers 0.
- Latency:
  - A store in cycle N gives `out_valid`=1 with that byte in cycle N+1 if the FIFO was empty.
  - `byte_count` updates in cycle N+1.
- `out_data` is registered and driven from the head entry. It is stable while `out_valid`=1 and `out_ready`=0.
- Sustained throughput is one push and one pop per cycle.
- `drained` is registered: it rises one cycle after both DONE and empty hold, and falls one cycle after either stops holding.
- Reset asserted mid-operation:
  - All state clears immediately; in-flight bytes are lost.
  - After `RST_N` rises, the first capture is on the first RUN-state store edge.

## Test plan
- Reset then RUN; `sw R2, ROM` (9'b001_010_111) with `DataOut`=8'hA5, `out_ready`=1 → next cycle `out_valid`=1, `out_data`=A5, `byte_count`=1; the cycle after, `out_valid`=0.
- `DEPTH`=8, `out_ready`=0; 9 stores of 8'h01..8'h09, with the 9th store at `PC`=10'h024 → `byte_count`=8, `overflow`=1, `overflow_pc`=024. Then raise `out_ready` → drains exactly 01..08 in order.
- FIFO full and `out_ready`=1 with a store of 8'h55 in the same cycle → push accepted, no overflow, 55 is the last byte out.
- Same store encoding with `ProgState`=10, and `lw R0, RIM` (9'b000_000_111) in RUN → no push. In DONE with an empty FIFO, `drained`=1 one cycle later.
- 3 bytes queued, `ProgState`→11 with `out_ready`=1 → `out_valid`=0 and nothing pops. Return to 10 → 3 bytes drain, then `drained`=1.
- 4 bytes queued, `RST_N` pulsed low mid-stream → all outputs 0 asynchronously. After release, a new store of 8'h7E → `out_data`=7E, `byte_count`=1.
